// File: rtl/ap_ctrl_profiler_if.sv
// Record drain port of the ap_ctrl profiler.
// The profiler drives valid/data as master; the downstream dump stage is the slave.
interface ap_ctrl_profiler_if #(
    parameter int TS_W  = 32,
    parameter int CNT_W = 16
);
    localparam int REC_W = TS_W + 2 * CNT_W;

    logic             rec_valid;
    logic             rec_ready;
    logic [REC_W-1:0] rec_data;

    modport master (
        output rec_valid,
        output rec_data,
        input  rec_ready
    );

    modport slave (
        input  rec_valid,
        input  rec_data,
        output rec_ready
    );
endinterface

// File: rtl/ap_ctrl_profiler.sv
// Per-transaction profiler for an HLS ap_ctrl_hs block.
// It timestamps each start, counts latency and loop iterations until done,
// and queues {start_ts, latency, iters} records in a small fall-through FIFO.
module ap_ctrl_profiler #(
    parameter int TS_W       = 32,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int DROP_W     = 8
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              enable,
    input  logic              clear,
    input  logic              mon_ap_start,
    input  logic              mon_ap_ready,
    input  logic              mon_ap_done,
    input  logic              mon_iter_end,
    ap_ctrl_profiler_if.master rec,
    output logic              busy,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count
);
    localparam int REC_W = TS_W + 2 * CNT_W;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [AW:0]      FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [TS_W-1:0]    ts_q;
    logic [TS_W-1:0]    start_ts_q, start_ts_d;
    logic [CNT_W-1:0]   lat_q, lat_d;
    logic [CNT_W-1:0]   iters_q, iters_d;
    logic [CNT_W-1:0]   lat_inc, iters_inc, rec_lat, rec_iters;
    logic               push;
    logic [REC_W-1:0]   push_data;

    logic [REC_W-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_q, rd_q;
    logic [AW:0]        count_q;
    logic               fifo_full, fifo_valid, pop, push_ok;

    // ap_ready only matters for protocol checking, never for the counters.
    logic               unused_ready;
    assign unused_ready = mon_ap_ready;

    // Free-running timestamp; wraps naturally and ignores enable/clear.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    // FSM state and per-transaction counters.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= IDLE;
            start_ts_q <= '0;
            lat_q      <= '0;
            iters_q    <= '0;
        end else begin
            state_q    <= state_d;
            start_ts_q <= start_ts_d;
            lat_q      <= lat_d;
            iters_q    <= iters_d;
        end
    end

    // Next state, counter updates and record assembly; the done cycle itself counts toward latency.
    always_comb begin
        state_d    = state_q;
        start_ts_d = start_ts_q;
        lat_d      = lat_q;
        iters_d    = iters_q;
        push       = 1'b0;
        lat_inc    = (lat_q == CNT_MAX) ? lat_q : lat_q + CNT_W'(1);
        iters_inc  = (iters_q == CNT_MAX) ? iters_q : iters_q + CNT_W'(1);
        rec_lat    = lat_inc;
        rec_iters  = mon_iter_end ? iters_inc : iters_q;
        push_data  = {start_ts_q, rec_lat, rec_iters};
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable && mon_ap_start) begin
                        state_d    = RUN;
                        start_ts_d = ts_q;
                        lat_d      = '0;
                        iters_d    = '0;
                    end
                end
                RUN: begin
                    lat_d   = lat_inc;
                    iters_d = rec_iters;
                    if (mon_ap_done) begin
                        push = 1'b1;
                        if (enable && mon_ap_start) begin
                            start_ts_d = ts_q;
                            lat_d      = '0;
                            iters_d    = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy       = (state_q == RUN);
    assign fifo_valid = (count_q != '0);
    assign fifo_full  = (count_q == FIFO_FULL);
    assign pop        = fifo_valid && rec.rec_ready;
    assign push_ok    = push && (!fifo_full || pop);

    assign rec.rec_valid = fifo_valid;
    assign rec.rec_data  = fifo_valid ? mem[rd_q] : '0;

    // Record storage; a push while full is only written when the head leaves in the same cycle.
    always_ff @(posedge ap_clk) begin
        if (push_ok && !clear) begin
            mem[wr_q] <= push_data;
        end
    end

    // FIFO pointers, occupancy and drop accounting; clear wipes all of it.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            if (push_ok) begin
                wr_q <= wr_q + AW'(1);
            end else if (push) begin
                overflow <= 1'b1;
                if (drop_count != {DROP_W{1'b1}}) begin
                    drop_count <= drop_count + DROP_W'(1);
                end
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_ap_ctrl_profiler.sv
// Bench for ap_ctrl_profiler: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level reference model.
module tb_ap_ctrl_profiler;
    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        enable, clear;
    logic        mon_ap_start, mon_ap_ready, mon_ap_done, mon_iter_end;
    logic        busy, overflow;
    logic [7:0]  drop_count;

    ap_ctrl_profiler_if #(.TS_W(32), .CNT_W(16)) rec_if ();

    ap_ctrl_profiler #(.TS_W(32), .CNT_W(16), .FIFO_DEPTH(8), .DROP_W(8)) dut (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .enable       (enable),
        .clear        (clear),
        .mon_ap_start (mon_ap_start),
        .mon_ap_ready (mon_ap_ready),
        .mon_ap_done  (mon_ap_done),
        .mon_iter_end (mon_iter_end),
        .rec          (rec_if),
        .busy         (busy),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    // 10 ns clock.
    always #5 ap_clk = ~ap_clk;

    // Reference model: transaction view built from timestamps and pulse counts.
    logic [31:0] ts_m;
    logic [31:0] st_m;
    bit          run_m;
    int          it_m;
    bit          ovf_m;
    int          drop_m;
    logic [63:0] q_m[$];

    int vectors     = 0;
    int miscompares = 0;

    task automatic modelReset();
        q_m.delete();
        run_m  = 1'b0;
        ovf_m  = 1'b0;
        drop_m = 0;
        it_m   = 0;
        st_m   = '0;
        ts_m   = '0;
    endtask

    task automatic modelEdge();
        logic [31:0] lat;
        int          its;
        bit          pop;
        pop = (q_m.size() != 0) && rec_if.rec_ready;
        if (clear) begin
            q_m.delete();
            ovf_m  = 1'b0;
            drop_m = 0;
            run_m  = 1'b0;
        end else if (run_m && mon_ap_done) begin
            lat = ts_m - st_m;
            if (lat > 32'd65535) lat = 32'd65535;
            its = it_m + int'(mon_iter_end);
            if (its > 65535) its = 65535;
            if (pop) void'(q_m.pop_front());
            if (q_m.size() < 8) begin
                q_m.push_back({st_m, lat[15:0], 16'(its)});
            end else begin
                ovf_m = 1'b1;
                if (drop_m < 255) drop_m++;
            end
            if (enable && mon_ap_start) begin
                st_m = ts_m;
                it_m = 0;
            end else begin
                run_m = 1'b0;
            end
        end else begin
            if (pop) void'(q_m.pop_front());
            if (run_m) begin
                it_m += int'(mon_iter_end);
            end else if (enable && mon_ap_start) begin
                run_m = 1'b1;
                st_m  = ts_m;
                it_m  = 0;
            end
        end
        ts_m = ts_m + 32'd1;
    endtask

    task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkValue("rec_valid", 64'(rec_if.rec_valid), 64'(q_m.size() != 0));
        if (q_m.size() != 0) checkValue("rec_data", rec_if.rec_data, q_m[0]);
        checkValue("busy", 64'(busy), 64'(run_m));
        checkValue("overflow", 64'(overflow), 64'(ovf_m));
        checkValue("drop_count", 64'(drop_count), 64'(drop_m));
    endtask

    // Drive one cycle of inputs at the falling edge, let the DUT and model take the rising edge, check at the next fall.
    task automatic applyStimulus(input bit en, input bit st, input bit dn, input bit it, input bit rdy, input bit clr);
        enable           = en;
        mon_ap_start     = st;
        mon_ap_ready     = st;
        mon_ap_done      = dn;
        mon_iter_end     = it;
        rec_if.rec_ready = rdy;
        clear            = clr;
        @(posedge ap_clk);
        modelEdge();
        @(negedge ap_clk);
        checkOutput();
    endtask

    task automatic idleCycles(input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    // Start (optional), len-1 run cycles, then a done cycle len cycles after the start.
    task automatic runTxn(input bit startFirst, input bit en, input int len, input int step, input int nIt,
                          input bit rdy, input bit rdyDone, input bit b2b);
        if (startFirst) applyStimulus(en, 1'b1, 1'b0, 1'b0, rdy, 1'b0);
        for (int c = 1; c < len; c++)
            applyStimulus(en, 1'b0, 1'b0, (c % step == 0) && (c / step <= nIt), rdy, 1'b0);
        applyStimulus(en, b2b, 1'b1, (len % step == 0) && (len / step <= nIt), rdyDone, 1'b0);
    endtask

    task automatic checkAllZero(input string tag);
        checkValue({tag, "_valid"}, 64'(rec_if.rec_valid), 64'd0);
        checkValue({tag, "_data"}, rec_if.rec_data, 64'd0);
        checkValue({tag, "_busy"}, 64'(busy), 64'd0);
        checkValue({tag, "_ovf"}, 64'(overflow), 64'd0);
        checkValue({tag, "_drop"}, 64'(drop_count), 64'd0);
    endtask

    initial begin
        ap_rst_n         = 1'b1;
        enable           = 1'b0;
        clear            = 1'b0;
        mon_ap_start     = 1'b0;
        mon_ap_ready     = 1'b0;
        mon_ap_done      = 1'b0;
        mon_iter_end     = 1'b0;
        rec_if.rec_ready = 1'b0;
        modelReset();
        #1 ap_rst_n = 1'b0;
        #2 checkAllZero("reset");
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        $display("[TB] single transaction");
        idleCycles(10, 1'b0);
        runTxn(1'b1, 1'b1, 15, 3, 3, 1'b0, 1'b0, 1'b0);
        checkValue("t1_valid", 64'(rec_if.rec_valid), 64'd1);
        checkValue("t1_data", rec_if.rec_data, {32'd10, 16'd15, 16'd3});
        checkValue("t1_busy", 64'(busy), 64'd0);
        idleCycles(7, 1'b1);

        $display("[TB] back-to-back transactions");
        runTxn(1'b1, 1'b1, 7, 1, 0, 1'b0, 1'b0, 1'b1);
        checkValue("t2_busy", 64'(busy), 64'd1);
        runTxn(1'b0, 1'b1, 7, 1, 0, 1'b0, 1'b0, 1'b0);
        checkValue("t2_first", rec_if.rec_data, {32'd33, 16'd7, 16'd0});
        idleCycles(1, 1'b1);
        checkValue("t2_second", rec_if.rec_data, {32'd40, 16'd7, 16'd0});
        idleCycles(1, 1'b1);

        $display("[TB] overflow with stalled consumer");
        for (int k = 0; k < 10; k++) runTxn(1'b1, 1'b1, 3 + k, 1, k, 1'b0, 1'b0, 1'b0);
        checkValue("t3_ovf", 64'(overflow), 64'd1);
        checkValue("t3_drop", 64'(drop_count), 64'd2);

        $display("[TB] full FIFO with coincident pop");
        runTxn(1'b1, 1'b1, 4, 1, 2, 1'b0, 1'b1, 1'b0);
        checkValue("t4_drop_same", 64'(drop_count), 64'd2);
        runTxn(1'b1, 1'b1, 4, 1, 2, 1'b0, 1'b0, 1'b0);
        checkValue("t4_drop_full", 64'(drop_count), 64'd3);
        for (int c = 0; c < 20; c++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, c[0], 1'b0);
        checkValue("t4_drained", 64'(rec_if.rec_valid), 64'd0);

        $display("[TB] saturation and disabled start");
        runTxn(1'b1, 1'b1, 65600, 1, 100000, 1'b1, 1'b1, 1'b0);
        checkValue("t5_lat", 64'(rec_if.rec_data[31:16]), 64'hFFFF);
        checkValue("t5_iters", 64'(rec_if.rec_data[15:0]), 64'hFFFF);
        idleCycles(2, 1'b1);
        runTxn(1'b1, 1'b0, 5, 1, 2, 1'b1, 1'b1, 1'b0);
        checkValue("t5_no_rec", 64'(rec_if.rec_valid), 64'd0);

        $display("[TB] clear during RUN");
        for (int k = 0; k < 3; k++) runTxn(1'b1, 1'b1, 2 + k, 1, 1, 1'b0, 1'b0, 1'b0);
        runTxn(1'b1, 1'b1, 3, 1, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkAllZero("t6_clear");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkValue("t6_orphan", 64'(rec_if.rec_valid), 64'd0);

        $display("[TB] async reset during RUN");
        for (int k = 0; k < 3; k++) runTxn(1'b1, 1'b1, 2 + k, 1, 1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #2 ap_rst_n = 1'b0;
        #1 checkAllZero("t6_rst");
        enable       = 1'b0;
        mon_ap_start = 1'b0;
        mon_ap_ready = 1'b0;
        mon_iter_end = 1'b0;
        modelReset();
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        $display("[TB] random traffic");
        for (int c = 0; c < 600; c++) begin
            applyStimulus($urandom_range(0, 7) != 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 4) == 0,
                          $urandom_range(0, 1) == 1,
                          (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                          $urandom_range(0, 99) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
